// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, functs, ALU-op enum and boot defaults for the cpu core
package cpu_pkg;
  localparam logic [31:0] DEF_START_ADRS = 32'h0040_0000;
  localparam int HALF_CYCLE = 5;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;
endpackage

// File: rtl/cpu_regfile.sv
// regfile: 32x32 register file, two combinational reads, one write port, $0 hardwired to zero
module regfile (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [32];
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
  // clear on reset; $0 is never written so it always reads zero
  always_ff @(posedge clk_cpu or negedge reset)
    if (!reset)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0)
      regs[wa] <= wd;
endmodule

// File: rtl/cpu.sv
// cpu: single-cycle MIPS-subset core with private word-addressed data memory
module cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] START_ADRS = DEF_START_ADRS,
  parameter int          DMEM_WORDS = 256
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic [31:0] inst,
  output logic [31:0] pc
);
  localparam int AW = $clog2(DMEM_WORDS);
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, wa;
  logic [15:0] imm;
  logic [31:0] a, b, opb, y, wd, ld, pc4, pc_next;
  logic        we, use_imm, zext, mem_we, mem_rd, link, jmp, jr, br_taken;
  logic [AW-1:0] idx;
  alu_op_e     alu_op;
  logic [31:0] dmem [DMEM_WORDS];
  assign {op, rs, rt, rd, shamt, funct} = inst;
  assign imm = inst[15:0];
  regfile rf0 (
    .clk_cpu(clk_cpu), .reset(reset), .ra1(rs), .ra2(rt),
    .we(we), .wa(wa), .wd(wd), .rd1(a), .rd2(b)
  );
  // decode: undefined op/funct leave every write enable low and fall through to pc+4
  always_comb begin
    we = 1'b0;
    wa = rt;
    alu_op = ALU_ADD;
    use_imm = 1'b0;
    zext = 1'b0;
    mem_we = 1'b0;
    mem_rd = 1'b0;
    link = 1'b0;
    jmp = 1'b0;
    jr = 1'b0;
    case (op)
      OP_RTYPE: begin
        wa = rd;
        we = 1'b1;
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_SLT: alu_op = ALU_SLT;
          FN_SLL: alu_op = ALU_SLL;
          FN_SRL: alu_op = ALU_SRL;
          FN_JR:  begin we = 1'b0; jr = 1'b1; end
          default: we = 1'b0;
        endcase
      end
      OP_ADDI: begin we = 1'b1; use_imm = 1'b1; end
      OP_ANDI: begin we = 1'b1; use_imm = 1'b1; zext = 1'b1; alu_op = ALU_AND; end
      OP_ORI:  begin we = 1'b1; use_imm = 1'b1; zext = 1'b1; alu_op = ALU_OR; end
      OP_LUI:  begin we = 1'b1; alu_op = ALU_LUI; end
      OP_LW:   begin we = 1'b1; use_imm = 1'b1; mem_rd = 1'b1; end
      OP_SW:   begin use_imm = 1'b1; mem_we = 1'b1; end
      OP_J:    jmp = 1'b1;
      OP_JAL:  begin we = 1'b1; wa = 5'd31; link = 1'b1; jmp = 1'b1; end
      default: ;
    endcase
  end
  // ALU; its ADD result also serves as the load/store address
  always_comb begin
    opb = use_imm ? (zext ? {16'h0, imm} : {{16{imm[15]}}, imm}) : b;
    y = a + opb;
    case (alu_op)
      ALU_SUB: y = a - opb;
      ALU_AND: y = a & opb;
      ALU_OR:  y = a | opb;
      ALU_SLT: y = {31'b0, $signed(a) < $signed(opb)};
      ALU_SLL: y = b << shamt;
      ALU_SRL: y = b >> shamt;
      ALU_LUI: y = {imm, 16'h0};
      default: ;
    endcase
  end
  assign idx = y[AW+1:2];
  assign ld = dmem[idx];
  assign wd = link ? pc4 : mem_rd ? ld : y;
  assign pc4 = pc + 32'd4;
  assign br_taken = (op == OP_BEQ && a == b) || (op == OP_BNE && a != b);
  assign pc_next = br_taken ? pc4 + {{14{imm[15]}}, imm, 2'b00} :
                   jmp ? {pc4[31:28], inst[25:0], 2'b00} :
                   jr ? {a[31:2], 2'b00} : pc4;
  // program counter, boots at START_ADRS
  always_ff @(posedge clk_cpu or negedge reset)
    if (!reset) pc <= START_ADRS;
    else pc <= pc_next;
  // data memory, cleared on reset, written by SW on the commit edge
  always_ff @(posedge clk_cpu or negedge reset)
    if (!reset)
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
    else if (mem_we)
      dmem[idx] <= b;
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: table vectors, corner sequences and random programs checked against an instruction-level model
module tb_cpu;
  import cpu_pkg::*;
  localparam int DW = 256;
  localparam logic [31:0] SA = 32'h0040_0000;
  logic clk_cpu = 1'b0;
  logic reset = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] pc;
  int nvec = 0;
  int nerr = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [DW];
  logic [31:0] m_pc;
  typedef struct {
    logic [31:0] i;
    int          r;
    logic [31:0] v;
    logic [31:0] d;
  } vec_t;
  vec_t tbl [19];

  cpu #(.START_ADRS(SA), .DMEM_WORDS(DW)) dut (
    .clk_cpu(clk_cpu), .reset(reset), .inst(inst), .pc(pc)
  );

  always #(HALF_CYCLE) clk_cpu = ~clk_cpu;

  function automatic logic [31:0] r_(input logic [4:0] s, t, d, sh, input logic [5:0] fn);
    return {6'h00, s, t, d, sh, fn};
  endfunction
  function automatic logic [31:0] i_(input logic [5:0] o, input logic [4:0] s, t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_regs[k] = '0;
    for (int k = 0; k < DW; k++) m_mem[k] = '0;
    m_pc = SA;
  endtask

  // architectural effect of one instruction, straight from the ISA rules
  task automatic model_step(input logic [31:0] w);
    int o, f, s, t, d, sh, dst;
    logic [31:0] a, b, se, ze, pc4, npc, val, ea;
    o = int'(w[31:26]); s = int'(w[25:21]); t = int'(w[20:16]);
    d = int'(w[15:11]); sh = int'(w[10:6]); f = int'(w[5:0]);
    a = m_regs[s]; b = m_regs[t];
    ze = {16'h0, w[15:0]};
    se = w[15] ? ze - 32'h0001_0000 : ze;
    pc4 = m_pc + 4;
    npc = pc4;
    dst = 0;
    val = '0;
    ea = a + se;
    case (o)
      0: case (f)
        'h20: begin dst = d; val = a + b; end
        'h22: begin dst = d; val = a - b; end
        'h24: begin dst = d; val = a & b; end
        'h25: begin dst = d; val = a | b; end
        'h2A: begin dst = d; val = ($signed(a) < $signed(b)) ? 1 : 0; end
        'h00: begin dst = d; val = b << sh; end
        'h02: begin dst = d; val = b >> sh; end
        'h08: npc = a - (a % 4);
        default: ;
      endcase
      'h08: begin dst = t; val = a + se; end
      'h0C: begin dst = t; val = a & ze; end
      'h0D: begin dst = t; val = a | ze; end
      'h0F: begin dst = t; val = ze * 65536; end
      'h23: begin dst = t; val = m_mem[(ea / 4) % DW]; end
      'h2B: m_mem[(ea / 4) % DW] = b;
      'h04: if (a == b) npc = pc4 + se * 4;
      'h05: if (a != b) npc = pc4 + se * 4;
      'h02: npc = (pc4 & 32'hF000_0000) + {4'h0, w[25:0], 2'b00};
      'h03: begin npc = (pc4 & 32'hF000_0000) + {4'h0, w[25:0], 2'b00}; dst = 31; val = pc4; end
      default: ;
    endcase
    if (dst != 0) m_regs[dst] = val;
    m_pc = npc;
  endtask

  task automatic step(input logic [31:0] w);
    inst = w;
    model_step(w);
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic do_reset();
    inst = '0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic compare_state(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_pc"}, pc, m_pc);
    for (int k = 31; k >= 0; k--) if (dut.rf0.regs[k] !== m_regs[k]) bad = k;
    chk($sformatf("%s_reg%0d", tag, bad), dut.rf0.regs[bad], m_regs[bad]);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] s, t, d, sh;
    logic [15:0] im, br;
    int k;
    s = 5'($urandom_range(0, 7));
    t = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 8));
    sh = 5'($urandom);
    im = 16'($urandom);
    br = 16'($urandom_range(0, 15)) - 16'd8;
    k = $urandom_range(0, 18);
    case (k)
      0: return r_(s, t, d, 0, 6'h20);
      1: return r_(s, t, d, 0, 6'h22);
      2: return r_(s, t, d, 0, 6'h24);
      3: return r_(s, t, d, 0, 6'h25);
      4: return r_(s, t, d, 0, 6'h2A);
      5: return r_(0, t, d, sh, 6'h00);
      6: return r_(0, t, d, sh, 6'h02);
      7: return r_(s, 0, 0, 0, 6'h08);
      8: return i_(6'h08, s, t, im);
      9: return i_(6'h0C, s, t, im);
      10: return i_(6'h0D, s, t, im);
      11: return i_(6'h0F, 0, t, im);
      12: return i_(6'h23, s, t, im);
      13: return i_(6'h2B, s, t, im);
      14: return i_(6'h04, s, t, br);
      15: return i_(6'h05, s, t, br);
      16: return {6'h02, 26'($urandom)};
      17: return {6'h03, 26'($urandom)};
      default: return ($urandom_range(0, 1) == 1) ? r_(s, t, d, 0, 6'h3F) : i_(6'h3F, s, t, im);
    endcase
  endfunction

  initial begin
    logic [31:0] acc, p;
    tbl[0]  = '{i_(6'h08, 0, 1, 16'd5),      1,  32'd5,          32'd4};
    tbl[1]  = '{i_(6'h08, 0, 2, 16'hFFFD),   2,  32'hFFFF_FFFD,  32'd4};
    tbl[2]  = '{r_(1, 2, 3, 0, 6'h20),       3,  32'd2,          32'd4};
    tbl[3]  = '{r_(2, 1, 4, 0, 6'h22),       4,  32'hFFFF_FFF8,  32'd4};
    tbl[4]  = '{r_(2, 1, 5, 0, 6'h2A),       5,  32'd1,          32'd4};
    tbl[5]  = '{i_(6'h0F, 0, 6, 16'h1234),   6,  32'h1234_0000,  32'd4};
    tbl[6]  = '{i_(6'h0D, 6, 6, 16'h5678),   6,  32'h1234_5678,  32'd4};
    tbl[7]  = '{i_(6'h2B, 0, 6, 16'd8),      6,  32'h1234_5678,  32'd4};
    tbl[8]  = '{i_(6'h23, 0, 7, 16'd8),      7,  32'h1234_5678,  32'd4};
    tbl[9]  = '{i_(6'h23, 0, 8, 16'h0408),   8,  32'h1234_5678,  32'd4};
    tbl[10] = '{i_(6'h04, 1, 1, 16'd2),      0,  32'd0,          32'd12};
    tbl[11] = '{i_(6'h05, 1, 1, 16'd2),      0,  32'd0,          32'd4};
    tbl[12] = '{i_(6'h08, 0, 0, 16'd7),      0,  32'd0,          32'd4};
    tbl[13] = '{r_(0, 1, 10, 4, 6'h00),      10, 32'h0000_0050,  32'd4};
    tbl[14] = '{r_(0, 4, 11, 28, 6'h02),     11, 32'h0000_000F,  32'd4};
    tbl[15] = '{i_(6'h0C, 6, 12, 16'hFF00),  12, 32'h0000_5600,  32'd4};
    tbl[16] = '{i_(6'h3F, 0, 13, 16'd1),     13, 32'd0,          32'd4};
    tbl[17] = '{r_(6, 4, 9, 0, 6'h24),       9,  32'h1234_5678,  32'd4};
    tbl[18] = '{r_(1, 2, 14, 0, 6'h3F),      14, 32'd0,          32'd4};
    model_reset();
    repeat (5) begin
      @(posedge clk_cpu);
      #1;
      chk("rst_pc", pc, SA);
      acc = '0;
      for (int k = 0; k < 32; k++) acc |= dut.rf0.regs[k];
      chk("rst_regs", acc, 32'h0);
    end
    reset = 1'b1;
    step(32'h0);
    chk("boot_pc", pc, 32'h0040_0004);
    do_reset();
    repeat (4) step(32'h0);
    chk("pre_jal_pc", pc, 32'h0040_0010);
    step({6'h03, 26'h010_0040});
    chk("jal_ra", dut.rf0.regs[31], 32'h0040_0014);
    chk("jal_pc", pc, 32'h0040_0100);
    step(r_(31, 0, 0, 0, 6'h08));
    chk("jr_pc", pc, 32'h0040_0014);
    do_reset();
    for (int k = 0; k < 19; k++) begin
      p = pc;
      step(tbl[k].i);
      chk($sformatf("vec%0d_reg%0d", k, tbl[k].r), dut.rf0.regs[tbl[k].r], tbl[k].v);
      chk($sformatf("vec%0d_pc", k), pc, p + tbl[k].d);
    end
    chk("sw_mem", dut.dmem[2], 32'h1234_5678);
    for (int n = 0; n < 600; n++) begin
      step(rand_inst());
      compare_state($sformatf("rnd%0d", n));
    end
    for (int k = 0; k < DW; k++) chk($sformatf("mem%0d", k), dut.dmem[k], m_mem[k]);
    do_reset();
    step(i_(6'h08, 0, 6, 16'h0055));
    chk("mid_setup", dut.rf0.regs[6], 32'h55);
    inst = i_(6'h2B, 0, 6, 16'd16);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_pc", pc, SA);
    chk("mid_mem", dut.dmem[4], 32'h0);
    chk("mid_reg6", dut.rf0.regs[6], 32'h0);
    @(posedge clk_cpu);
    #1;
    chk("mid_mem_edge", dut.dmem[4], 32'h0);
    chk("mid_pc_edge", pc, SA);
    inst = '0;
    reset = 1'b1;
    model_reset();
    step(32'h0);
    chk("restart_pc", pc, 32'h0040_0004);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cpu.md
# cpu

Single-cycle 32-bit MIPS-subset processor core. Fetches one instruction per `clk_cpu` cycle from an external instruction ROM addressed by `pc`, and executes it in the same cycle. The core contains a 32×32 register file and a private word-addressed data memory. It is the top compute block of the CPU32 design.

## Interface
- `START_ADRS`, default 32'h0040_0000: reset/boot address of the first instruction. This value is also used by the system as the ROM base.
- `DMEM_WORDS`, default 256: depth of the internal data memory in 32-bit words. Must be a power of two.

Ports:
- `clk_cpu` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `inst` input 32: instruction word at `pc`. Combinational from the external ROM.
- `pc` output 32: registered program counter, word aligned.

## Operation
- Formats follow MIPS32:
  - R-type: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
  - I-type: op, rs, rt, imm[15:0].
  - J-type: op, target[25:0].
- Supported R-type instructions (op 0), by funct:
  - ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed).
  - SLL 0x00 (rt << shamt), SRL 0x02.
  - JR 0x08.
- Supported I/J-type instructions, by op:
  - ADDI 0x08 (sign-extended imm), ANDI 0x0C and ORI 0x0D (zero-extended imm), LUI 0x0F (imm << 16).
  - LW 0x23, SW 0x2B.
  - BEQ 0x04, BNE 0x05.
  - J 0x02, JAL 0x03.
- Arithmetic is 32-bit two's complement; overflow wraps with no trap.
- Register $0 always reads 0; writes to it are discarded.
- Writeback register selection: rd for R-type, rt for I-type, $31 for JAL (writes pc+4).
- Load/store address = rs + sext(imm). The data memory index is address[log2(DMEM_WORDS)+1:2]; higher bits and bits [1:0] are ignored, so accesses wrap around the memory.
- Next PC, in priority order:
  - BEQ/BNE taken: pc+4 + (sext(imm) << 2).
  - J/JAL: {pc+4[31:28], target, 2'b00}.
  - JR: rs with bits [1:0] forced to 0.
  - Otherwise: pc+4.
- Any undefined opcode or funct executes as a NOP: no register or memory write, pc+4.
- There are no delay slots.

## Timing
- While `reset` is low, asynchronously and immediately:
  - `pc` = START_ADRS.
  - All 32 registers = 0.
  - Data memory is cleared to 0.
- On the first rising edge after `reset` rises, the instruction at START_ADRS commits and `pc` becomes its successor.
- Latency is one cycle per instruction. The register write, memory write and pc update for an instruction all occur on the same rising edge.
- Register file reads are combinational. A write and a read of the same register in one cycle returns the old value, and the new value is visible in the next cycle.
- LW data is read combinationally and written to the register on the edge. SW writes on the edge.
- An LW in the cycle after an SW to the same word returns the stored value.
- Asserting reset mid-program aborts the instruction in flight with no partial writes, and execution restarts at START_ADRS.
- `pc` wraps modulo 2^32.

## Structure
- Shared package `cpu_pkg` holds:
  - Opcode and funct localparams.
  - ALU-op enum: ADD, SUB, AND, OR, SLT, SLL, SRL, LUI.
  - Defaults for START_ADRS and the half-cycle constant used by benches.
- Sub-module `regfile`:
  - 32×32 storage in array `regs`.
  - Two combinational read ports, one synchronous write port, asynchronous active-low clear.
  - Benches access `regs` hierarchically through instance `rf0`.
- Decode, ALU, next-PC logic and data memory array `dmem` reside in `cpu`.

## Test plan
- Reset: hold `reset` low for 5 cycles → `pc` = 32'h0040_0000 throughout and all registers read 0. Release `reset` → after 1 edge `pc` = 32'h0040_0004.
- ALU: ADDI $1,$0,5; ADDI $2,$0,-3; ADD $3,$1,$2; SUB $4,$2,$1; SLT $5,$2,$1; LUI $6,0x1234; ORI $6,$6,0x5678 → $3=2, $4=32'hFFFF_FFF8, $5=1, $6=32'h1234_5678.
- Memory: SW $6,8($0); LW $7,8($0); LW $8,(8+4*DMEM_WORDS)($0) → $7 = $8 = 32'h1234_5678.
- Branch: BEQ on equal registers with imm=2 → `pc` advances by 12. BNE on the same registers → `pc` advances by 4. ADDI $0,$0,7 → $0 stays 0.
- Jumps: JAL at 32'h0040_0010 → $31 = 32'h0040_0014 and `pc` = the target. A following JR $31 → `pc` = 32'h0040_0014.
- Reset mid-run: pull `reset` low during an SW cycle, between clock edges → `pc` = START_ADRS immediately and the stored word remains 0.
